// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access stage:
//   - RV32I load/store func3 encodings
//   - FSM state type (IDLE, WAIT)
//   - write-back bundle carried to the WB stage
//   - helpers for alignment checking, byte-enable generation and store-lane
//     replication
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
  } wb_bundle_t;

  // Size is encoded in func3[1:0]; the unsigned flag in func3[2] does not
  // affect alignment. The reserved size 3 is held to word alignment.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (lane[0] == 1'b0);
      2'd2:    ok = (lane == 2'd0);
      default: ok = (lane == 2'd0);
    endcase
    return ok;
  endfunction

  // Byte enables for an access of the given size starting at the given lane.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across all lanes so the enabled lanes carry it
  // regardless of the address offset.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      2'd0:    wd = {4{data[7:0]}};
      2'd1:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/acknowledge port between the memory stage (master) and
// the data memory (slave).
//   req    master->slave  access request, held until ack
//   we     master->slave  1 = store
//   addr   master->slave  word-aligned byte address (ADDR_W bits)
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  access complete
//   rdata  slave->master  read word, valid with ack
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data extraction: selects the addressed byte or halfword
// from the returned memory word and sign- or zero-extends it to 32 bits.
//   rdata  in   32  word returned by the data memory
//   lane   in   2   byte offset of the access within the word
//   func3  in   3   load width/sign (LB, LH, LW, LBU, LHU)
//   data   out  32  extended load result
// -----------------------------------------------------------------------------
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by width/sign extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;

    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase

    // Aligned halfwords only ever start at lane 0 or lane 2.
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end

    case (func3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_BU:   data = {24'h00_0000, byte_s};
      F3_HU:   data = {16'h0000, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// RV32I memory-access stage downstream of the execute ALU. Non-memory bundles
// pass straight to write-back with one cycle of latency; loads and stores are
// issued on a req/ack data-memory port with byte-lane steering, load
// extension and misalignment detection. Upstream is stalled while an access
// is outstanding.
//
// Build option: MEM_TIMEOUT_EN -- when defined, an access that sees no ack
// within TIMEOUT_CYCLES WAIT cycles is aborted and reported through
// o_misaligned / o_bad_addr with no write-back.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), synchronous active-high reset
//   i_valid .. i_func3    execute result bundle
//   o_stall               upstream must hold its bundle stable
//   dmem                  data-memory port (mem_stage_if.master)
//   o_wb_*                registered write-back bundle, o_wb_valid pulses once
//                         per retired bundle
//   o_misaligned          one-cycle fault pulse
//   o_bad_addr            faulting address, held until the next fault
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_func3,

  output logic        o_stall,

  mem_stage_if.master dmem,

  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_reg_write,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic [31:0] o_bad_addr
);

  mem_state_t  state_r,      state_next_s;
  logic        req_r,        req_next_s;
  logic        we_r,         we_next_s;
  logic [31:0] addr_r,       addr_next_s;
  logic [3:0]  be_r,         be_next_s;
  logic [31:0] wdata_r,      wdata_next_s;
  logic [4:0]  rd_r,         rd_next_s;
  logic [2:0]  func3_r,      func3_next_s;
  logic        reg_write_r,  reg_write_next_s;
  logic        mem_to_reg_r, mem_to_reg_next_s;
  wb_bundle_t  wb_r,         wb_next_s;
  logic        misaligned_r, misaligned_next_s;
  logic [31:0] bad_addr_r,   bad_addr_next_s;
  logic        stall_s;

  logic        mem_op_s;
  logic        aligned_s;
  logic [31:0] load_data_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign mem_op_s  = i_valid & (i_mem_read | i_mem_write);
  assign aligned_s = is_aligned(i_func3[1:0], i_alu_out[1:0]);

  load_align u_load_align (
    .rdata (dmem.rdata),
    .lane  (addr_r[1:0]),
    .func3 (func3_r),
    .data  (load_data_s)
  );

  // Next-state, request latching, write-back and stall generation.
  always_comb begin
    state_next_s      = state_r;
    req_next_s        = req_r;
    we_next_s         = we_r;
    addr_next_s       = addr_r;
    be_next_s         = be_r;
    wdata_next_s      = wdata_r;
    rd_next_s         = rd_r;
    func3_next_s      = func3_r;
    reg_write_next_s  = reg_write_r;
    mem_to_reg_next_s = mem_to_reg_r;
    wb_next_s         = wb_r;
    wb_next_s.valid   = 1'b0;
    misaligned_next_s = 1'b0;
    bad_addr_next_s   = bad_addr_r;
    stall_s           = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_next_s        = cnt_r;
`endif

    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          if (aligned_s) begin
            stall_s           = 1'b1;
            state_next_s      = WAIT;
            req_next_s        = 1'b1;
            // Read+write together is handled as a store.
            we_next_s         = i_mem_write;
            addr_next_s       = i_alu_out;
            be_next_s         = lane_be(i_func3[1:0], i_alu_out[1:0]);
            rd_next_s         = i_rd;
            func3_next_s      = i_func3;
            reg_write_next_s  = i_reg_write;
            mem_to_reg_next_s = i_mem_to_reg;
            if (i_mem_write) begin
              wdata_next_s = store_wdata(i_func3[1:0], i_store_data);
            end else begin
              wdata_next_s = 32'h0000_0000;
            end
`ifdef MEM_TIMEOUT_EN
            cnt_next_s = '0;
`endif
          end else begin
            misaligned_next_s = 1'b1;
            bad_addr_next_s   = i_alu_out;
          end
        end else if (i_valid) begin
          wb_next_s.valid     = 1'b1;
          wb_next_s.rd        = i_rd;
          wb_next_s.reg_write = i_reg_write;
          wb_next_s.data      = i_alu_out;
        end else begin
          state_next_s = IDLE;
        end
      end

      WAIT: begin
        // Releasing the stall in the ack cycle lets upstream advance on the
        // same edge that retires this access.
        stall_s = ~dmem.ack;
        if (dmem.ack) begin
          state_next_s    = IDLE;
          req_next_s      = 1'b0;
          wb_next_s.valid = 1'b1;
          wb_next_s.rd    = rd_r;
          if (we_r) begin
            wb_next_s.reg_write = 1'b0;
            wb_next_s.data      = addr_r;
          end else begin
            wb_next_s.reg_write = reg_write_r;
            if (mem_to_reg_r) begin
              wb_next_s.data = load_data_s;
            end else begin
              wb_next_s.data = addr_r;
            end
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt_r == TO_LAST) begin
            stall_s           = 1'b0;
            state_next_s      = IDLE;
            req_next_s        = 1'b0;
            misaligned_next_s = 1'b1;
            bad_addr_next_s   = addr_r;
          end else begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_next_s = WAIT;
`endif
        end
      end

      default: begin
        state_next_s = IDLE;
        req_next_s   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= IDLE;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      be_r         <= 4'h0;
      wdata_r      <= 32'h0000_0000;
      rd_r         <= 5'd0;
      func3_r      <= 3'd0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      wb_r         <= '0;
      misaligned_r <= 1'b0;
      bad_addr_r   <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
      cnt_r        <= '0;
`endif
    end else begin
      state_r      <= state_next_s;
      req_r        <= req_next_s;
      we_r         <= we_next_s;
      addr_r       <= addr_next_s;
      be_r         <= be_next_s;
      wdata_r      <= wdata_next_s;
      rd_r         <= rd_next_s;
      func3_r      <= func3_next_s;
      reg_write_r  <= reg_write_next_s;
      mem_to_reg_r <= mem_to_reg_next_s;
      wb_r         <= wb_next_s;
      misaligned_r <= misaligned_next_s;
      bad_addr_r   <= bad_addr_next_s;
`ifdef MEM_TIMEOUT_EN
      cnt_r        <= cnt_next_s;
`endif
    end
  end

  assign o_stall        = stall_s;
  assign dmem.req       = req_r;
  assign dmem.we        = we_r;
  assign dmem.addr      = {addr_r[ADDR_W-1:2], 2'b00};
  assign dmem.be        = be_r;
  assign dmem.wdata     = wdata_r;
  assign o_wb_valid     = wb_r.valid;
  assign o_wb_rd        = wb_r.rd;
  assign o_wb_reg_write = wb_r.reg_write;
  assign o_wb_data      = wb_r.data;
  assign o_misaligned   = misaligned_r;
  assign o_bad_addr     = bad_addr_r;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage: ALU pass-through, loads with
// extension, stores with lane steering, misalignment, back-to-back bundles,
// reset during an access and the WAIT-cycle limit (MEM_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misaligned;
  logic [31:0] bad_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .i_alu_out      (alu_out),
    .i_store_data   (store_data),
    .i_rd           (rd),
    .i_reg_write    (reg_write),
    .i_mem_to_reg   (mem_to_reg),
    .i_mem_read     (mem_read),
    .i_mem_write    (mem_write),
    .i_func3        (func3),
    .o_stall        (stall),
    .dmem           (dmem),
    .o_wb_valid     (wb_valid),
    .o_wb_rd        (wb_rd),
    .o_wb_reg_write (wb_reg_write),
    .o_wb_data      (wb_data),
    .o_misaligned   (misaligned),
    .o_bad_addr     (bad_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] r, input logic rw, input logic m2r,
                        input logic mr, input logic mw, input logic [2:0] f3);
    valid = v; alu_out = a; store_data = sd; rd = r; reg_write = rw;
    mem_to_reg = m2r; mem_read = mr; mem_write = mw; func3 = f3;
  endtask

  task automatic clear_op();
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_op(); dmem.ack = 1'b0; dmem.rdata = 32'h0;
    tick(); tick();
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%h exp=0", dmem.req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%h exp=0", wb_valid); end
    total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%h exp=0", misaligned); end
    total++; if (bad_addr !== 32'h0) begin bad++; $display("FAIL reset_bad_addr got=%h exp=0", bad_addr); end
    total++; if ({dmem.we, dmem.be, dmem.addr, dmem.wdata} !== 69'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {dmem.we, dmem.be, dmem.addr, dmem.wdata}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    set_op(1'b1, 32'h0000_0042, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%h exp=0", stall); end
    tick();
    clear_op();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%h exp=1", wb_valid); end
    total++; if (wb_data !== 32'h42) begin bad++; $display("FAIL alu_wb_data got=%h exp=42", wb_data); end
    total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd5) begin bad++; $display("FAIL alu_wb_rd got=%h/%h exp=1/5", wb_reg_write, wb_rd); end
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL alu_req got=%h exp=0", dmem.req); end
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall2 got=%h exp=0", stall); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_pulse got=%h exp=0", wb_valid); end
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                           input logic [3:0] exp_be, input logic [31:0] exp_data, input int waits);
    int stalls;
    stalls = 0;
    set_op(1'b1, addr, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, f3);
    @(negedge clk); if (stall === 1'b1) stalls++;
    tick();
    total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0) begin bad++; $display("FAIL load_req got=%h/%h exp=1/0", dmem.req, dmem.we); end
    total++; if (dmem.addr !== (addr & 32'hFFFF_FFFC)) begin bad++; $display("FAIL load_addr got=%h exp=%h", dmem.addr, addr & 32'hFFFF_FFFC); end
    total++; if (dmem.be !== exp_be) begin bad++; $display("FAIL load_be got=%b exp=%b", dmem.be, exp_be); end
    total++; if (dmem.wdata !== 32'h0) begin bad++; $display("FAIL load_wdata got=%h exp=0", dmem.wdata); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_wb_early got=%h exp=0", wb_valid); end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); if (stall === 1'b1) stalls++;
      tick();
    end
    total++; if (dmem.req !== 1'b1) begin bad++; $display("FAIL load_req_held got=%h exp=1", dmem.req); end
    dmem.ack = 1'b1; dmem.rdata = word;
    @(negedge clk); if (stall === 1'b1) stalls++;
    tick();
    dmem.ack = 1'b0; dmem.rdata = 32'h0; clear_op();
    total++; if (stalls != waits + 1) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=%0d", stalls, waits + 1); end
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%h exp=0", dmem.req); end
    total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd7) begin bad++; $display("FAIL load_wb got=%h/%h/%h exp=1/1/7", wb_valid, wb_reg_write, wb_rd); end
    total++; if (wb_data !== exp_data) begin bad++; $display("FAIL load_data got=%h exp=%h", wb_data, exp_data); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_wb_pulse got=%h exp=0", wb_valid); end
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data,
                            input logic also_read, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    set_op(1'b1, addr, data, 5'd9, 1'b1, 1'b0, also_read, 1'b1, f3);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL store_stall got=%h exp=1", stall); end
    tick();
    total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1) begin bad++; $display("FAIL store_req got=%h/%h exp=1/1", dmem.req, dmem.we); end
    total++; if (dmem.addr !== (addr & 32'hFFFF_FFFC)) begin bad++; $display("FAIL store_addr got=%h exp=%h", dmem.addr, addr & 32'hFFFF_FFFC); end
    total++; if (dmem.be !== exp_be) begin bad++; $display("FAIL store_be got=%b exp=%b", dmem.be, exp_be); end
    total++; if (dmem.wdata !== exp_wdata) begin bad++; $display("FAIL store_wdata got=%h exp=%h", dmem.wdata, exp_wdata); end
    dmem.ack = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_ack_stall got=%h exp=0", stall); end
    tick();
    dmem.ack = 1'b0; clear_op();
    total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL store_wb got=%h/%h exp=1/0", wb_valid, wb_reg_write); end
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL store_req_drop got=%h exp=0", dmem.req); end
    tick();
  endtask

  task automatic test_misaligned(input logic [31:0] addr, input logic [2:0] f3);
    set_op(1'b1, addr, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, f3);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%h exp=0", stall); end
    tick();
    clear_op();
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL mis_req got=%h exp=0", dmem.req); end
    total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%h exp=1", misaligned); end
    total++; if (bad_addr !== addr) begin bad++; $display("FAIL mis_bad_addr got=%h exp=%h", bad_addr, addr); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mis_wb got=%h exp=0", wb_valid); end
    tick();
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%h exp=0", misaligned); end
    total++; if (bad_addr !== addr) begin bad++; $display("FAIL mis_bad_addr_hold got=%h exp=%h", bad_addr, addr); end
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    tick();
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    set_op(1'b1, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_load got=%h/%h exp=1/deadbeef", wb_valid, wb_data); end
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%h exp=0", stall); end
    tick();
    clear_op();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_rd !== 5'd3) begin bad++; $display("FAIL b2b_alu got=%h/%h/%h exp=1/1234/3", wb_valid, wb_data, wb_rd); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%h exp=0", wb_valid); end
  endtask

  task automatic test_reset_wait();
    set_op(1'b1, 32'h0000_4000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    total++; if (dmem.req !== 1'b1) begin bad++; $display("FAIL rstw_req got=%h exp=1", dmem.req); end
    rst = 1'b1; clear_op();
    tick();
    rst = 1'b0;
    total++; if (dmem.req !== 1'b0) begin bad++; $display("FAIL rstw_req_drop got=%h exp=0", dmem.req); end
    dmem.ack = 1'b1; dmem.rdata = 32'h5555_5555;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstw_stall got=%h exp=0", stall); end
    tick();
    dmem.ack = 1'b0;
    total++; if (wb_valid !== 1'b0 || dmem.req !== 1'b0) begin bad++; $display("FAIL rstw_spurious_ack got=%h/%h exp=0/0", wb_valid, dmem.req); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstw_wb got=%h exp=0", wb_valid); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    set_op(1'b1, 32'h0000_5000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL to_stall_%0d got=%h exp=1", i, stall); end
      tick();
    end
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL to_release got=%h exp=0", stall); end
    tick();
    clear_op();
    total++; if (dmem.req !== 1'b0 || misaligned !== 1'b1) begin bad++; $display("FAIL to_abort got=%h/%h exp=0/1", dmem.req, misaligned); end
    total++; if (bad_addr !== 32'h0000_5000 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_fault got=%h/%h exp=5000/0", bad_addr, wb_valid); end
    tick();
    total++; if (misaligned !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_after got=%h/%h exp=0/0", misaligned, wb_valid); end
  endtask
`else
  task automatic test_timeout();
    set_op(1'b1, 32'h0000_5000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (stall !== 1'b1 || dmem.req !== 1'b1 || misaligned !== 1'b0) begin bad++; $display("FAIL wait_hold_%0d got=%h/%h/%h exp=1/1/0", i, stall, dmem.req, misaligned); end
      tick();
    end
    dmem.ack = 1'b1; dmem.rdata = 32'h0BAD_F00D;
    tick();
    dmem.ack = 1'b0; clear_op();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL wait_retire got=%h/%h exp=1/0badf00d", wb_valid, wb_data); end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load(32'h0000_1003, F3_B,  32'h80FF_0000, 4'b1000, 32'hFFFF_FF80, 3);
    test_load(32'h0000_1003, F3_BU, 32'h80FF_0000, 4'b1000, 32'h0000_0080, 3);
    test_load(32'h0000_0002, F3_H,  32'h8001_1234, 4'b1100, 32'hFFFF_8001, 0);
    test_load(32'h0000_0002, F3_HU, 32'h8001_1234, 4'b1100, 32'h0000_8001, 1);
    test_load(32'h0000_0040, F3_W,  32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0);
    test_load(32'h0000_0001, F3_B,  32'h0000_7F00, 4'b0010, 32'h0000_007F, 0);
    test_store(32'h0000_2002, F3_H, 32'h1234_ABCD, 1'b0, 4'b1100, 32'hABCD_ABCD);
    test_store(32'h0000_0001, F3_B, 32'h0000_0077, 1'b0, 4'b0010, 32'h7777_7777);
    test_store(32'h0000_0010, F3_W, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D);
    test_misaligned(32'h0000_3001, F3_W);
    test_misaligned(32'h0000_0003, F3_HU);
    test_back_to_back();
    test_reset_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
